minibus_arbiter: RTL and testbench



---
 rtl/minibus_arbiter_pkg.sv | 22 ++
 rtl/minibus_arbiter_if.sv | 28 ++
 rtl/minibus_arbiter.sv | 139 +++++++++++++
 tb/tb_minibus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minibus_arbiter_pkg.sv
// Shared minibus types and constants.
//   arb_state_t        : arbiter FSM state
//   grant_t            : which master owns / last owned the bus
//   MINIBUS_WIDTH_WORD : m_width code for a 32-bit access
//   MINIBUS_TIMEOUT    : default no-ack timeout in BUSY cycles
package minibus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam logic [2:0] MINIBUS_WIDTH_WORD = 3'b010;
  localparam int         MINIBUS_TIMEOUT    = 16;

endpackage

// File: rtl/minibus_arbiter_if.sv
// Minibus link between the arbiter and the RAM slave.
//   master modport : arbiter side, drives sel/ren/wen/addr/wdata/width,
//                    receives ack/err/rdata
//   slave  modport : RAM side, the mirror image
interface minibus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_sel;
  logic              m_ren;
  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [2:0]        m_width;
  logic              m_ack;
  logic              m_err;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_sel, m_ren, m_wen, m_addr, m_wdata, m_width,
    input  m_ack, m_err, m_rdata
  );

  modport slave (
    input  m_sel, m_ren, m_wen, m_addr, m_wdata, m_width,
    output m_ack, m_err, m_rdata
  );
endinterface

// File: rtl/minibus_arbiter.sv
// Two-master (instr fetch, data) to one-slave minibus arbiter.
// Round-robin between simultaneous requesters, registered bus request,
// completion routed back to the owner, no-ack timeout turned into an error.
//   clk, rst          : clock, asynchronous active-high reset
//   i_ren/i_addr      : instr read request (held until i_ack/i_err)
//   i_ack/i_err/i_rdata : instr completion (1-cycle pulses, rdata valid on ack)
//   d_ren/d_wen/d_addr/d_wdata/d_width : data request (ren&wen means write)
//   d_ack/d_err/d_rdata : data completion
//   bus               : minibus master side
module minibus_arbiter
  import minibus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MINIBUS_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_width,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  minibus_arbiter_if.master bus
);

  arb_state_t        state;
  grant_t            last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              sel_q;
  logic              ren_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        width_q;

  logic d_req;
  logic grant_i;
  logic grant_d;
  logic busy;
  logic timed_out;
  logic done_ack;
  logic done_err;

  assign d_req = d_ren | d_wen;

  // Data wins when it is alone, or when both request and instr went last.
  assign grant_d = d_req & (~i_ren | (last_grant == GRANT_I));
  assign grant_i = i_ren & ~grant_d;

  assign busy      = (state != IDLE);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Bus error outranks ack; timeout only fires when the slave stays silent.
  assign done_err = busy & (bus.m_err | (~bus.m_ack & timed_out));
  assign done_ack = busy & ~bus.m_err & bus.m_ack;

  assign i_ack   = (state == BUSY_I) & done_ack;
  assign i_err   = (state == BUSY_I) & done_err;
  assign d_ack   = (state == BUSY_D) & done_ack;
  assign d_err   = (state == BUSY_D) & done_err;
  assign i_rdata = i_ack ? bus.m_rdata : '0;
  assign d_rdata = d_ack ? bus.m_rdata : '0;

  assign bus.m_sel   = sel_q;
  assign bus.m_ren   = ren_q;
  assign bus.m_wen   = wen_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_width = width_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cnt        <= '0;
      sel_q      <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_i) begin
            state      <= BUSY_I;
            last_grant <= GRANT_I;
            sel_q      <= 1'b1;
            ren_q      <= 1'b1;
            wen_q      <= 1'b0;
            addr_q     <= i_addr;
            wdata_q    <= '0;
            width_q    <= MINIBUS_WIDTH_WORD;
          end else if (grant_d) begin
            state      <= BUSY_D;
            last_grant <= GRANT_D;
            sel_q      <= 1'b1;
            // A simultaneous read+write request is treated as a write.
            ren_q      <= d_ren & ~d_wen;
            wen_q      <= d_wen;
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
            width_q    <= d_width;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done_ack | done_err) begin
            // Clearing here guarantees a full IDLE cycle with ren/wen low.
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            width_q <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Scoreboard bench for minibus_arbiter: stimulus predicts grant order and
// responses into queues, a bus-slave model replays planned responses, and a
// monitor checks bus fields and master completions cycle by cycle.
module tb_minibus_arbiter;
  import minibus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = MINIBUS_TIMEOUT;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ren;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          i_err;
  logic [DW-1:0] i_rdata;
  logic          d_ren;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_width;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_rdata;

  minibus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  minibus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {R_ACK, R_ERR, R_BOTH, R_HANG} resp_t;

  typedef struct {
    bit            is_d;
    bit            ren;
    bit            wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    width;
    resp_t         resp;
    int            delay;   // BUSY cycle index (0-based) at which the slave answers
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t plan_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   model_last_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t rand_txn(input bit is_d);
    txn_t t;
    int   p;
    t.is_d  = is_d;
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.width = 3'($urandom_range(0, 2));
    case ($urandom_range(0, 2))
      0:       begin t.ren = 1; t.wen = 0; end
      1:       begin t.ren = 0; t.wen = 1; end
      default: begin t.ren = 1; t.wen = 1; end
    endcase
    p = $urandom_range(0, 99);
    t.resp  = (p < 75) ? R_ACK : (p < 85) ? R_ERR : (p < 93) ? R_BOTH : R_HANG;
    t.delay = $urandom_range(0, 3);
    t.rdata = $urandom;
    return t;
  endfunction

  // Slave model: answers each bus transaction as planned by the stimulus.
  initial begin : slave
    txn_t cur;
    bit   active = 0;
    int   cyc = 0;
    bit   hit;
    bus.m_ack = 0; bus.m_err = 0; bus.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.m_sel) begin
        active = 0; bus.m_ack = 0; bus.m_err = 0; bus.m_rdata = $urandom;
      end else begin
        if (!active) begin
          check("slave_plan_avail", plan_q.size() != 0, 1);
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          else cur.resp = R_HANG;
          active = 1; cyc = 0;
        end else cyc++;
        hit = (cur.resp != R_HANG) && (cyc == cur.delay);
        bus.m_ack   = hit && (cur.resp == R_ACK || cur.resp == R_BOTH);
        bus.m_err   = hit && (cur.resp == R_ERR || cur.resp == R_BOTH);
        bus.m_rdata = hit ? cur.rdata : DW'($urandom);
      end
    end
  end

  // Monitor: pops the expected transaction when the bus is selected.
  initial begin : monitor
    txn_t cur;
    bit   in_txn = 0, just_done = 0, done;
    int   b = 0;
    bit   e_ack, e_err;
    forever begin
      @(negedge clk);
      if (rst) begin in_txn = 0; just_done = 0; continue; end
      if (just_done) begin
        check("turnaround_sel_en", {bus.m_sel, bus.m_ren, bus.m_wen}, 3'b000);
        just_done = 0;
      end else if (!in_txn && bus.m_sel) begin
        check("exp_q_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front(); in_txn = 1; b = 0;
        end
      end
      if (in_txn) begin
        b++;
        check("m_sel", bus.m_sel, 1);
        check("m_ren_wen", {bus.m_ren, bus.m_wen},
              cur.is_d ? {cur.ren & ~cur.wen, cur.wen} : 2'b10);
        check("m_addr", bus.m_addr, cur.addr);
        check("m_wdata", bus.m_wdata, cur.is_d ? cur.wdata : '0);
        check("m_width", bus.m_width, cur.is_d ? cur.width : MINIBUS_WIDTH_WORD);
        done  = (cur.resp == R_HANG) ? (b == TO) : (b == cur.delay + 1);
        e_ack = done && (cur.resp == R_ACK);
        e_err = done && (cur.resp != R_ACK);
        check("i_ack_err", {i_ack, i_err}, cur.is_d ? 2'b00 : {e_ack, e_err});
        check("d_ack_err", {d_ack, d_err}, cur.is_d ? {e_ack, e_err} : 2'b00);
        check("i_rdata", i_rdata, (!cur.is_d && e_ack) ? cur.rdata : '0);
        check("d_rdata", d_rdata, (cur.is_d && e_ack) ? cur.rdata : '0);
        if (done) begin in_txn = 0; just_done = 1; end
      end else begin
        check("idle_resp", {i_ack, i_err, d_ack, d_err}, 4'b0000);
        check("idle_rdata", {i_rdata, d_rdata}, '0);
        check("idle_bus", {bus.m_sel, bus.m_ren, bus.m_wen}, 3'b000);
      end
    end
  end

  // One round: chosen masters request together and each holds until answered.
  task automatic run_round(input bit has_i, input bit has_d, input txn_t ti, input txn_t td,
                           input int exp_first, input int exp_last);
    bit i_pend, d_pend;
    int k = 0, first = -1, last = -1;
    ti.is_d = 0; td.is_d = 1;
    if (has_i && has_d) begin
      // Both request: the port that did not go last goes first, so the
      // owner of the final grant equals the previous last grant.
      if (!model_last_d) begin exp_q.push_back(td); exp_q.push_back(ti); plan_q.push_back(td); plan_q.push_back(ti); end
      else               begin exp_q.push_back(ti); exp_q.push_back(td); plan_q.push_back(ti); plan_q.push_back(td); end
    end else if (has_i) begin
      exp_q.push_back(ti); plan_q.push_back(ti); model_last_d = 0;
    end else if (has_d) begin
      exp_q.push_back(td); plan_q.push_back(td); model_last_d = 1;
    end
    @(posedge clk); #1;
    i_ren = has_i; i_addr = ti.addr;
    d_ren = has_d & td.ren; d_wen = has_d & td.wen;
    d_addr = td.addr; d_wdata = td.wdata; d_width = td.width;
    i_pend = has_i; d_pend = has_d;
    while ((i_pend || d_pend) && k < 200) begin
      @(negedge clk);
      if (i_ack || i_err || d_ack || d_err) begin
        if (first < 0) first = k;
        last = k;
      end
      if (i_ack || i_err) i_pend = 0;
      if (d_ack || d_err) d_pend = 0;
      @(posedge clk); #1;
      if (!i_pend) begin i_ren = 0; i_addr = $urandom; end
      if (!d_pend) begin d_ren = 0; d_wen = 0; end
      k++;
    end
    check("round_complete", {i_pend, d_pend}, 2'b00);
    if (i_pend || d_pend) begin
      i_ren = 0; d_ren = 0; d_wen = 0;
      exp_q.delete(); plan_q.delete();
    end
    if (exp_first >= 0) check("first_resp_cycle", first, exp_first);
    if (exp_last >= 0)  check("last_resp_cycle", last, exp_last);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    txn_t ti, td;
    int   w;
    rst = 1; i_ren = 0; i_addr = '0; d_ren = 0; d_wen = 0;
    d_addr = '0; d_wdata = '0; d_width = '0;
    @(negedge clk);
    check("rst_bus", {bus.m_sel, bus.m_ren, bus.m_wen, bus.m_addr, bus.m_width}, '0);
    check("rst_resp", {i_ack, i_err, d_ack, d_err}, 4'b0000);
    @(posedge clk); #1; rst = 0;

    // Contention from reset: D,I three times, RAM-like one-cycle ack.
    for (int r = 0; r < 3; r++) begin
      ti = rand_txn(0); td = rand_txn(1);
      ti.resp = R_ACK; ti.delay = 1; td.resp = R_ACK; td.delay = 1;
      run_round(1, 1, ti, td, 2, 5);
    end

    // Single instr read.
    ti = rand_txn(0);
    ti.addr = 32'h0000_0040; ti.resp = R_ACK; ti.delay = 1; ti.rdata = 32'hDEAD_BEEF;
    run_round(1, 0, ti, td, 2, 2);

    // Data byte write.
    td = rand_txn(1);
    td.ren = 0; td.wen = 1; td.addr = 32'h0000_0103; td.width = 3'b000;
    td.wdata = 32'h0000_00AB; td.resp = R_ACK; td.delay = 1;
    run_round(0, 1, ti, td, 2, 2);

    // Timeout: answer lands on the 16th BUSY cycle (cycle 1..16).
    td = rand_txn(1); td.ren = 1; td.wen = 0; td.resp = R_HANG;
    run_round(0, 1, ti, td, TO, TO);

    // Bus error together with ack on an instr fetch.
    ti = rand_txn(0); ti.resp = R_BOTH; ti.delay = 1;
    run_round(1, 0, ti, td, 2, 2);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      int mode = $urandom_range(1, 3);
      ti = rand_txn(0); td = rand_txn(1);
      run_round(mode[0], mode[1], ti, td, -1, -1);
    end

    // Reset in the middle of a data write.
    td = rand_txn(1); td.ren = 0; td.wen = 1; td.resp = R_HANG;
    ti.is_d = 0; td.is_d = 1;
    exp_q.push_back(td); plan_q.push_back(td);
    @(posedge clk); #1;
    d_wen = 1; d_addr = td.addr; d_wdata = td.wdata; d_width = td.width;
    w = 0;
    do begin @(negedge clk); w++; end while (!bus.m_sel && w < 10);
    check("rst_mid_busy_seen", bus.m_sel, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 check("rst_async_drop", {bus.m_sel, bus.m_wen, d_ack, d_err}, 4'b0000);
    d_wen = 0;
    exp_q.delete(); plan_q.delete();
    model_last_d = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    ti = rand_txn(0); ti.resp = R_ACK; ti.delay = 1;
    run_round(1, 0, ti, td, 2, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
